jtag_uart_tx_arbiter: RTL

- Shares the single TX byte path of the JTAG-UART bridge (tx_din/tx_vld/busy) between N_REQ independent message sources, e.g. the control block plus status/debug producers.
- Round-robin grant, locked for a whole message (until req_last) so messages never interleave.
- Paces bytes against bridge busy.
- Sits between the requesters and the bridge TX inputs in the top level.

---
 rtl/jtag_uart_pkg.sv | 18 +
 rtl/jtag_uart_rr_pick.sv | 30 +++
 rtl/jtag_uart_tx_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/jtag_uart_pkg.sv
// Shared types for the JTAG-UART TX arbiter: FSM state encoding and header base.
// JTAG_UART_TX_PREFIX_EN adds the PFX/PGAP header states.
package jtag_uart_pkg;

    localparam logic [7:0] PREFIX_BASE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        GAP
`ifdef JTAG_UART_TX_PREFIX_EN
        ,
        PFX,
        PGAP
`endif
    } arb_state_t;

endpackage

// File: rtl/jtag_uart_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, returned as a one-hot grant plus a found flag.
module jtag_uart_rr_pick
    import jtag_uart_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic           vld
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(ptr) + i) % N);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_uart_tx_arbiter.sv
// Round-robin arbiter sharing the JTAG-UART bridge TX byte path between N_REQ
// message sources; grant is held per message. Optional header byte: JTAG_UART_TX_PREFIX_EN.
module jtag_uart_tx_arbiter
    import jtag_uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int MAX_MSG_LEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_rdy,
    output logic [7:0]         tx_din,
    output logic               tx_vld,
    input  logic               busy,
    output logic [N_REQ-1:0]   grant,
    output logic               active
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(MAX_MSG_LEN + 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q;
    logic [IDW-1:0]   idx_q;
    logic [IDW-1:0]   ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             rel_q;
    logic [7:0]       tx_din_p1;
    logic             tx_vld_p1;

    logic [N_REQ-1:0] pick_gnt;
    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    logic [7:0]       cur_data;
    logic             cur_vld;
    logic             cur_last;
    logic             load;
    logic             accept;
    logic             drop;
`ifdef JTAG_UART_TX_PREFIX_EN
    logic             hdr_send;
`endif

    jtag_uart_rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_pick (
        .req (req_vld),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) pick_idx = IDW'(i);
        end
    end

    // Current owner's byte lane, selected by the registered owner index.
    always_comb begin
        cur_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx_q == IDW'(i)) cur_data = req_data[8*i +: 8];
        end
        cur_vld  = req_vld[idx_q];
        cur_last = req_last[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accept  = 1'b0;
        drop    = 1'b0;
`ifdef JTAG_UART_TX_PREFIX_EN
        hdr_send = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    load = 1'b1;
`ifdef JTAG_UART_TX_PREFIX_EN
                    state_d = PFX;
`else
                    state_d = SEND;
`endif
                end
            end
`ifdef JTAG_UART_TX_PREFIX_EN
            PFX: begin
                if (!busy) begin
                    hdr_send = 1'b1;
                    state_d  = PGAP;
                end
            end
            PGAP: state_d = SEND;
`endif
            SEND: begin
                if (!busy && cur_vld) begin
                    accept  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                // One idle cycle after every strobe lets the bridge raise busy.
                if (rel_q) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: accepted byte becomes the bridge write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= IDW'(N_REQ - 1);
            cnt_q     <= '0;
            rel_q     <= 1'b0;
            tx_din_p1 <= 8'h00;
            tx_vld_p1 <= 1'b0;
        end else begin
`ifdef JTAG_UART_TX_PREFIX_EN
            tx_vld_p1 <= accept | hdr_send;
            if (hdr_send) tx_din_p1 <= PREFIX_BASE | 8'(idx_q);
`else
            tx_vld_p1 <= accept;
`endif
            if (accept) begin
                tx_din_p1 <= cur_data;
                cnt_q     <= cnt_q + 1'b1;
                rel_q     <= cur_last || (cnt_q == CW'(MAX_MSG_LEN - 1));
            end
            if (load) begin
                grant_q <= pick_gnt;
                idx_q   <= pick_idx;
                cnt_q   <= '0;
                rel_q   <= 1'b0;
            end
            if (drop) begin
                grant_q <= '0;
                ptr_q   <= idx_q;
            end
        end
    end

    assign req_rdy = accept ? grant_q : '0;
    assign tx_din  = tx_din_p1;
    assign tx_vld  = tx_vld_p1;
    assign grant   = grant_q;
    assign active  = |grant_q;

endmodule
